// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter sharing one I2C controller among N_REQ requesters.
// Latches the winner's fields, launches the controller, and reports read data or a timeout.
module i2c_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_rd_wr,
   input  logic [N_REQ-1:0]     req_wr,
   input  logic [7*N_REQ-1:0]   req_addr,
   input  logic [8*N_REQ-1:0]   req_cmd,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_grant,
   output logic [N_REQ-1:0]     req_done,
   output logic                 req_err,
   output logic [15:0]          rsp_data,
   output logic                 i2c_init,
   output logic                 i2c_rd_wr,
   output logic                 i2c_wr,
   output logic [6:0]           i2c_addr,
   output logic [7:0]           i2c_cmd,
   output logic [7:0]           i2c_data,
   input  logic                 i2c_done,
   input  logic [15:0]          i2c_o_data
);
   localparam int             IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW:0]    CNT_LAST  = (CW+1)'(TIMEOUT - 1);
   localparam logic [IW-1:0]  LAST_INIT = IW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [IW-1:0]     r_last;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     w_start;
   logic [IW-1:0]     w_win;
   logic              w_any;
   logic [CW-1:0]     r_cnt;
   logic [CW:0]       w_cnt_inc;
   logic              w_timeout;
   logic [N_REQ-1:0]  r_grant;
   logic              r_err;
   logic [15:0]       r_rsp;
   logic              r_rd_wr;
   logic              r_wr;
   logic [6:0]        r_addr;
   logic [7:0]        r_cmd;
   logic [7:0]        r_data;

   logic [6:0]        w_addr [N_REQ];
   logic [7:0]        w_cmd  [N_REQ];
   logic [7:0]        w_data [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_addr[gi] = req_addr[7*gi +: 7];
         assign w_cmd[gi]  = req_cmd[8*gi +: 8];
         assign w_data[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   assign w_any = |req_valid;

   // Walk from the farthest offset back to the start so the nearest valid requester wins.
   always_comb begin : p_arb
      int idx;
      w_start = (r_last == LAST_INIT) ? '0 : r_last + IW'(1);
      w_win   = '0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(w_start) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (req_valid[IW'(idx)]) begin
            w_win = IW'(idx);
         end
      end
   end

   // Counter saturates at TIMEOUT-1 because WAIT is left on that very value.
   assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);
   assign w_timeout = (w_cnt_inc == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_next = LAUNCH;
         LAUNCH:  w_state_next = WAIT;
         WAIT:    if (i2c_done || w_timeout) w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last  <= LAST_INIT;
         r_owner <= '0;
         r_grant <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rsp   <= '0;
         r_rd_wr <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_cmd   <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_win;
                  r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                  r_rd_wr <= req_rd_wr[w_win];
                  r_wr    <= req_wr[w_win];
                  r_addr  <= w_addr[w_win];
                  r_cmd   <= w_cmd[w_win];
                  r_data  <= w_data[w_win];
               end
            end
            LAUNCH: begin
               r_cnt <= '0;
            end
            WAIT: begin
               r_cnt <= w_cnt_inc[CW-1:0];
               if (i2c_done) begin
                  r_rsp <= r_rd_wr ? i2c_o_data : 16'h0000;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp <= 16'h0000;
                  r_err <= 1'b1;
               end
            end
            RESP: begin
               r_last  <= r_owner;
               r_grant <= '0;
            end
            default: ;
         endcase
      end
   end

   assign req_grant = r_grant;
   assign req_done  = (r_state == RESP) ? r_grant : '0;
   assign req_err   = r_err;
   assign rsp_data  = r_rsp;
   assign i2c_init  = (r_state == LAUNCH);
   assign i2c_rd_wr = r_rd_wr;
   assign i2c_wr    = r_wr;
   assign i2c_addr  = r_addr;
   assign i2c_cmd   = r_cmd;
   assign i2c_data  = r_data;

endmodule

// File: tb/tb_i2c_arb.sv
// Scoreboard bench for i2c_arb: planned grants are queued at stimulus time, a controller
// model answers launches, and an independent monitor checks every completion.
`timescale 1ns/1ps
module tb_i2c_arb;
   localparam int N  = 4;
   localparam int TO = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0, req_rd_wr = '0, req_wr = '0;
   logic [7*N-1:0]   req_addr = '0;
   logic [8*N-1:0]   req_cmd = '0, req_data = '0;
   logic [N-1:0]     req_grant, req_done;
   logic             req_err;
   logic [15:0]      rsp_data;
   logic             i2c_init, i2c_rd_wr, i2c_wr;
   logic [6:0]       i2c_addr;
   logic [7:0]       i2c_cmd, i2c_data;
   logic             i2c_done;
   logic [15:0]      i2c_o_data;

   logic             bfm_done = 1'b0, tb_done = 1'b0;
   logic [15:0]      bfm_data = '0, tb_data = '0;
   assign i2c_done   = bfm_done | tb_done;
   assign i2c_o_data = tb_done ? tb_data : bfm_data;

   i2c_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_wr(req_wr),
      .req_addr(req_addr), .req_cmd(req_cmd), .req_data(req_data),
      .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .rsp_data(rsp_data),
      .i2c_init(i2c_init), .i2c_rd_wr(i2c_rd_wr), .i2c_wr(i2c_wr),
      .i2c_addr(i2c_addr), .i2c_cmd(i2c_cmd), .i2c_data(i2c_data),
      .i2c_done(i2c_done), .i2c_o_data(i2c_o_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // dly = cycles from launch to i2c_done; 0 means the controller never answers
   typedef struct {
      int         owner;
      logic       rd_wr;
      logic       wr;
      logic [6:0] addr;
      logic [7:0] cmd;
      logic [7:0] data;
      int         dly;
      logic [15:0] odata;
   } txn_t;
   typedef struct {
      txn_t        t;
      logic        err;
      logic [15:0] rsp;
      int          at;
   } exp_t;

   txn_t launch_q[$];
   exp_t done_q[$];

   int n_checks = 0, n_pass = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [N-1:0] onehot(input int o);
      logic [N-1:0] v;
      v = '0;
      v[o] = 1'b1;
      return v;
   endfunction

   function automatic logic [24:0] pack(input txn_t t);
      return {t.rd_wr, t.wr, t.addr, t.cmd, t.data};
   endfunction

   // ---------------- requester field table and round-robin reference ----------------
   logic       f_rd [N], f_wr [N];
   logic [6:0] f_addr [N];
   logic [7:0] f_cmd [N], f_data [N];
   int         f_dly [N];
   logic [15:0] f_odata [N];
   int         last_m = N - 1;
   bit         hold_mode = 0;
   int         hold_left = 0;
   logic [15:0] last_rsp = '0;
   logic       last_err = 1'b0;

   task automatic set_fields(input int i, input logic rd, input logic wr, input logic [6:0] a,
                             input logic [7:0] c, input logic [7:0] d, input int dly,
                             input logic [15:0] od);
      f_rd[i] = rd; f_wr[i] = wr; f_addr[i] = a; f_cmd[i] = c; f_data[i] = d;
      f_dly[i] = dly; f_odata[i] = od;
   endtask

   task automatic rand_fields(input int i, input bit allow_to);
      int r, dly;
      r = allow_to ? int'($urandom_range(0, 9)) : 9;
      dly = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : int'($urandom_range(1, 6));
      set_fields(i, 1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                 dly, 16'($urandom));
   endtask

   // Grants go to masked requesters in circular order after the previous winner.
   task automatic plan(input logic [N-1:0] mask, input int count);
      txn_t t;
      int idx, k;
      idx = last_m;
      k = 0;
      while (k < count) begin
         idx = (idx + 1) % N;
         if (mask[idx]) begin
            t.owner = idx; t.rd_wr = f_rd[idx]; t.wr = f_wr[idx]; t.addr = f_addr[idx];
            t.cmd = f_cmd[idx]; t.data = f_data[idx]; t.dly = f_dly[idx]; t.odata = f_odata[idx];
            launch_q.push_back(t);
            k++;
         end
      end
      last_m = idx;
   endtask

   task automatic start_set(input logic [N-1:0] mask, input int count, input bit hold);
      plan(mask, count);
      if (hold) begin
         hold_left = count;
         hold_mode = 1;
      end
      for (int i = 0; i < N; i++) begin
         req_rd_wr[i] = f_rd[i];
         req_wr[i]    = f_wr[i];
         req_addr[7*i +: 7] = f_addr[i];
         req_cmd[8*i +: 8]  = f_cmd[i];
         req_data[8*i +: 8] = f_data[i];
      end
      req_valid = mask;
   endtask

   task automatic wait_idle();
      int budget;
      budget = 3000;
      while ((launch_q.size() != 0 || done_q.size() != 0 || req_valid != '0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("drain_within_budget", 64'(budget > 0), 64'd1);
      if (budget == 0) begin
         launch_q.delete();
         done_q.delete();
         req_valid = '0;
         hold_mode = 0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      check(name, {req_grant, req_done, req_err, rsp_data, i2c_init, i2c_rd_wr, i2c_wr,
                   i2c_addr, i2c_cmd, i2c_data}, 64'd0);
   endtask

   // ---------------- controller model and requester behaviour ----------------
   int   done_at = -1;
   logic init_prev = 1'b0;
   initial forever begin
      txn_t t;
      exp_t e;
      @(negedge clk);
      bfm_done = (done_at >= 0 && cyc == done_at);
      if (i2c_init) begin
         check("init_single_cycle", 64'(init_prev), 64'd0);
         if (launch_q.size() == 0) begin
            check("unexpected_init", 64'd1, 64'd0);
         end else begin
            t = launch_q.pop_front();
            check("grant_at_launch", 64'(req_grant), 64'(onehot(t.owner)));
            check("launch_fields", 64'({i2c_rd_wr, i2c_wr, i2c_addr, i2c_cmd, i2c_data}),
                  64'(pack(t)));
            e.t   = t;
            e.err = (t.dly == 0 || t.dly >= TO);
            e.rsp = (e.err || !t.rd_wr) ? 16'h0000 : t.odata;
            e.at  = e.err ? cyc + TO : cyc + t.dly + 1;
            done_q.push_back(e);
            done_at  = (t.dly == 0) ? -1 : cyc + t.dly;
            bfm_data = t.odata;
            if (!hold_mode) begin
               req_addr[7*t.owner +: 7] = 7'($urandom);
               req_cmd[8*t.owner +: 8]  = 8'($urandom);
               req_data[8*t.owner +: 8] = 8'($urandom);
               req_rd_wr[t.owner] = ~req_rd_wr[t.owner];
               req_wr[t.owner]    = ~req_wr[t.owner];
            end
         end
      end
      init_prev = i2c_init;
      if (req_done != '0) begin
         if (hold_mode) begin
            hold_left--;
            if (hold_left == 0) begin
               req_valid = '0;
               hold_mode = 0;
            end
         end else begin
            req_valid = req_valid & ~req_done;
         end
      end
   end

   // ---------------- monitor ----------------
   bit gap_due = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      check("grant_onehot0", 64'($onehot0(req_grant)), 64'd1);
      if (gap_due) begin
         check("idle_gap_grant", 64'(req_grant), 64'd0);
         gap_due = 0;
      end
      if (req_done != '0) begin
         if (done_q.size() == 0) begin
            check("unexpected_done", 64'(req_done), 64'd0);
         end else begin
            e = done_q.pop_front();
            $display("txn owner=%0d rd=%0d addr=%02h err=%0d rsp=%04h cyc=%0d",
                     e.t.owner, e.t.rd_wr, e.t.addr, e.err, e.rsp, cyc);
            check("done_owner", 64'(req_done), 64'(onehot(e.t.owner)));
            check("grant_at_done", 64'(req_grant), 64'(onehot(e.t.owner)));
            check("done_err", 64'(req_err), 64'(e.err));
            check("done_rsp", 64'(rsp_data), 64'(e.rsp));
            check("done_cycle", 64'(cyc), 64'(e.at));
            check("fields_held", 64'({i2c_rd_wr, i2c_wr, i2c_addr, i2c_cmd, i2c_data}),
                  64'(pack(e.t)));
            last_rsp = e.rsp;
            last_err = e.err;
            gap_due  = 1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("idle_no_init", 64'({i2c_init, req_grant}), 64'd0);
      end

      // contention held from reset: expect 0,1,2,3,0
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) rand_fields(i, 0);
      @(negedge clk);
      last_m = N - 1;
      start_set('1, 5, 1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle();

      // single write from requester 1
      set_fields(1, 1'b0, 1'b1, 7'h48, 8'h01, 8'hA5, 3, 16'h5A5A);
      start_set(4'b0010, 1, 0);
      wait_idle();

      // single read from requester 0
      set_fields(0, 1'b1, 1'b0, 7'h21, 8'h10, 8'h00, 5, 16'h1234);
      start_set(4'b0001, 1, 0);
      wait_idle();

      // timeout boundaries, then a normal read
      set_fields(1, 1'b1, 1'b0, 7'h11, 8'h22, 8'h33, 0, 16'h0BAD);
      set_fields(2, 1'b1, 1'b0, 7'h12, 8'h23, 8'h34, TO - 1, 16'hC0DE);
      set_fields(3, 1'b1, 1'b1, 7'h13, 8'h24, 8'h35, TO, 16'hDEAD);
      set_fields(0, 1'b1, 1'b0, 7'h14, 8'h25, 8'h36, 2, 16'h7E57);
      start_set('1, 4, 0);
      wait_idle();

      // spurious done while idle
      tb_data = 16'hBEEF;
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("spurious_no_done", 64'(req_done), 64'd0);
         check("spurious_rsp_held", 64'({req_err, rsp_data}), 64'({last_err, last_rsp}));
      end

      // reset in the middle of WAIT
      set_fields(1, 1'b0, 1'b1, 7'h30, 8'h31, 8'h32, 2, 16'h0);
      start_set(4'b0010, 1, 0);
      wait_idle();
      set_fields(2, 1'b1, 1'b0, 7'h40, 8'h41, 8'h42, 12, 16'h4444);
      start_set(4'b0100, 1, 0);
      budget = 50;
      while (launch_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("launch_before_reset", 64'(budget > 0), 64'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check_zero("reset_mid_wait");
      done_q.delete();
      launch_q.delete();
      last_m = N - 1;
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check("late_done_ignored", 64'({req_done, i2c_init}), 64'd0);
      end
      for (int i = 0; i < N; i++) rand_fields(i, 0);
      start_set('1, 4, 0);
      wait_idle();

      // randomized sets
      for (int s = 0; s < 30; s++) begin
         logic [N-1:0] mask;
         int cnt;
         mask = N'($urandom_range(1, (1 << N) - 1));
         cnt = 0;
         for (int i = 0; i < N; i++) begin
            rand_fields(i, 1);
            if (mask[i]) cnt++;
         end
         start_set(mask, cnt, 0);
         wait_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
